psum_accumulator: RTL and testbench

//  Downstream stage of the fusion unit: consumes the 8-bit partial sum produced each cycle by
//  the bitfusion top, sign/zero-extends it and accumulates a programmable number of terms
//  (one dot-product reduction) into a wide register.

---
 rtl/psum_accumulator.sv | 122 ++++++++++++
 tb/tb_psum_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Accumulates a programmable number of 8-bit partial sums (signed or unsigned) into a
// wide register and presents the finished reduction on a valid/ready output.
module psum_accumulator #(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_signed,
   input  logic [7:0]       psum_in,
   input  logic             psum_valid,
   output logic             psum_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             signed_q, signed_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic             overflow_q, overflow_d;

   logic [ACC_W-1:0] ext;
   logic [ACC_W:0]   sum_full;
   logic [ACC_W-1:0] sum;
   logic             add_ovf;

   assign ext      = signed_q ? {{(ACC_W-8){psum_in[7]}}, psum_in}
                              : {{(ACC_W-8){1'b0}}, psum_in};
   assign sum_full = {1'b0, acc_q} + {1'b0, ext};
   assign sum      = sum_full[ACC_W-1:0];

   // Signed wrap: both operands share a sign the result lost; unsigned wrap: carry out.
   assign add_ovf  = signed_q ? ((acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                              : sum_full[ACC_W];

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      count_d    = count_q;
      signed_d   = signed_q;
      acc_d      = acc_q;
      acc_out_d  = acc_out_q;
      overflow_d = overflow_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d      = cfg_len;
               signed_d   = cfg_signed;
               acc_d      = '0;
               count_d    = '0;
               overflow_d = 1'b0;
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            if (psum_valid) begin
               acc_d      = sum;
               count_d    = count_q + LEN_W'(1);
               overflow_d = overflow_q | add_ovf;
               // Compare before increment so a full-range length never sees a wrapped count.
               if (count_q == len_q) begin
                  acc_out_d = sum;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               if (start) begin
                  len_d      = cfg_len;
                  signed_d   = cfg_signed;
                  acc_d      = '0;
                  count_d    = '0;
                  overflow_d = 1'b0;
                  state_d    = ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         count_q    <= '0;
         signed_q   <= 1'b0;
         acc_q      <= '0;
         acc_out_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         count_q    <= count_d;
         signed_q   <= signed_d;
         acc_q      <= acc_d;
         acc_out_q  <= acc_out_d;
         overflow_q <= overflow_d;
      end
   end

   assign psum_ready = (state_q == ACCUM);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign acc_out    = acc_out_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: a 24-bit and a 9-bit instance share stimulus,
// expected results are queued per reduction and checked by a monitor on each output handshake.
module tb_psum_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] cfg_len = '0;
   logic       cfg_signed = 1'b0;
   logic [7:0] psum_in = '0;
   logic       psum_valid = 1'b0;
   logic       out_ready = 1'b1;

   logic        psum_ready, out_valid, busy, overflow;
   logic [23:0] acc_out;
   logic        psum_ready_b, out_valid_b, busy_b, overflow_b;
   logic [8:0]  acc_out_b;

   int checks = 0;
   int fails  = 0;

   logic [24:0] exp_q_a [$];
   logic [9:0]  exp_q_b [$];

   always #5 clk = ~clk;

   psum_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
      .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
      .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .overflow(overflow)
   );

   psum_accumulator #(.ACC_W(9), .LEN_W(8)) dut_b (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
      .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready_b),
      .acc_out(acc_out_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .busy(busy_b), .overflow(overflow_b)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every output handshake of either instance pops and checks one expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q_a.size() == 0) begin
            fails++;
            $display("[TB] FAIL result_a: got 0x%0h with no expected entry", acc_out);
         end else begin
            logic [24:0] e;
            e = exp_q_a.pop_front();
            if ({overflow, acc_out} !== e) begin
               fails++;
               $display("[TB] FAIL result_a: got acc 0x%0h ovf %0b, expected acc 0x%0h ovf %0b",
                        acc_out, overflow, e[23:0], e[24]);
            end
         end
      end
      if (!rst && out_valid_b && out_ready) begin
         checks++;
         if (exp_q_b.size() == 0) begin
            fails++;
            $display("[TB] FAIL result_b: got 0x%0h with no expected entry", acc_out_b);
         end else begin
            logic [9:0] e;
            e = exp_q_b.pop_front();
            if ({overflow_b, acc_out_b} !== e) begin
               fails++;
               $display("[TB] FAIL result_b: got acc 0x%0h ovf %0b, expected acc 0x%0h ovf %0b",
                        acc_out_b, overflow_b, e[8:0], e[9]);
            end
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Queue the hand-computed results for both widths and issue start from IDLE.
   task automatic applyStimulus(input logic sgn, input logic [7:0] len,
                                input logic [23:0] exp_a, input logic ovf_a,
                                input logic [8:0] exp_b, input logic ovf_b);
      exp_q_a.push_back({ovf_a, exp_a});
      exp_q_b.push_back({ovf_b, exp_b});
      start      = 1'b1;
      cfg_len    = len;
      cfg_signed = sgn;
      nextCycle();
      start = 1'b0;
   endtask

   task automatic feedTerm(input logic [7:0] val, input int gaps);
      int  n;
      logic done;
      psum_valid = 1'b0;
      psum_in    = 8'hAA;
      repeat (gaps) nextCycle();
      psum_in    = val;
      psum_valid = 1'b1;
      n    = 0;
      done = 1'b0;
      while (!done && n < 50) begin
         done = psum_ready;
         nextCycle();
         n++;
      end
      psum_valid = 1'b0;
      if (!done) checkOutput("feed_timeout", 32'd0, 32'd1);
   endtask

   task automatic finishRed();
      int n;
      checkOutput("out_valid_latency", {31'd0, out_valid}, 32'd1);
      n = 0;
      while (busy && n < 20) begin
         nextCycle();
         n++;
      end
      checkOutput("return_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #3;
      checkOutput("rst_acc_out", {8'd0, acc_out}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_psum_ready", {31'd0, psum_ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
      #20;
      rst = 1'b0;
      nextCycle();
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);

      // Unsigned 10+20+30+40; cfg changed mid-reduction must not matter.
      applyStimulus(1'b0, 8'd3, 24'd100, 1'b0, 9'd100, 1'b0);
      checkOutput("accum_busy", {31'd0, busy}, 32'd1);
      checkOutput("accum_ready", {31'd0, psum_ready}, 32'd1);
      cfg_len    = 8'd0;
      cfg_signed = 1'b1;
      feedTerm(8'd10, 0);
      feedTerm(8'd20, 0);
      feedTerm(8'd30, 0);
      checkOutput("not_done_early", {31'd0, out_valid}, 32'd0);
      feedTerm(8'd40, 0);
      finishRed();

      // Signed -1 + -128 = -129, then the same bytes unsigned = 383.
      applyStimulus(1'b1, 8'd1, 24'hFFFF7F, 1'b0, 9'h17F, 1'b0);
      cfg_signed = 1'b0;
      feedTerm(8'hFF, 0);
      feedTerm(8'h80, 0);
      finishRed();
      applyStimulus(1'b0, 8'd1, 24'd383, 1'b0, 9'd383, 1'b0);
      feedTerm(8'hFF, 0);
      feedTerm(8'h80, 0);
      finishRed();

      // psum_valid in IDLE is not consumed, then gapped input 5,6,7.
      psum_in    = 8'd99;
      psum_valid = 1'b1;
      repeat (3) nextCycle();
      checkOutput("idle_not_ready", {31'd0, psum_ready}, 32'd0);
      psum_valid = 1'b0;
      applyStimulus(1'b0, 8'd2, 24'd18, 1'b0, 9'd18, 1'b0);
      feedTerm(8'd5, 0);
      feedTerm(8'd6, 2);
      feedTerm(8'd7, 1);
      finishRed();

      // Single-term reduction, signed -128.
      applyStimulus(1'b1, 8'd0, 24'hFFFF80, 1'b0, 9'h180, 1'b0);
      feedTerm(8'h80, 0);
      finishRed();

      // Unsigned 255*3 = 765: carries out of 9 bits only.
      applyStimulus(1'b0, 8'd2, 24'd765, 1'b0, 9'd253, 1'b1);
      feedTerm(8'hFF, 0);
      feedTerm(8'hFF, 0);
      feedTerm(8'hFF, 0);
      finishRed();

      // Full-length reduction: 256 ones.
      applyStimulus(1'b0, 8'd255, 24'd256, 1'b0, 9'd256, 1'b0);
      for (int i = 0; i < 256; i++) feedTerm(8'd1, 0);
      finishRed();

      // Backpressure in DONE, then back-to-back start on the handshake.
      out_ready = 1'b0;
      applyStimulus(1'b0, 8'd1, 24'd7, 1'b0, 9'd7, 1'b0);
      feedTerm(8'd3, 0);
      feedTerm(8'd4, 0);
      checkOutput("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
      start      = 1'b1;
      cfg_len    = 8'd0;
      cfg_signed = 1'b1;
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         checkOutput("bp_acc_stable", {8'd0, acc_out}, 32'd7);
         checkOutput("bp_valid_held", {31'd0, out_valid}, 32'd1);
         checkOutput("bp_not_ready", {31'd0, psum_ready}, 32'd0);
      end
      exp_q_a.push_back({1'b0, 24'hFFFFFE});
      exp_q_b.push_back({1'b0, 9'h1FE});
      out_ready = 1'b1;
      nextCycle();
      start = 1'b0;
      checkOutput("b2b_accum", {31'd0, psum_ready}, 32'd1);
      checkOutput("b2b_valid_low", {31'd0, out_valid}, 32'd0);
      feedTerm(8'hFE, 0);
      finishRed();

      // Signed 127*3 = 381 wraps in 9 bits; overflow stays set in IDLE.
      applyStimulus(1'b1, 8'd2, 24'd381, 1'b0, 9'h17D, 1'b1);
      feedTerm(8'd127, 0);
      feedTerm(8'd127, 0);
      feedTerm(8'd127, 0);
      finishRed();
      repeat (2) nextCycle();
      checkOutput("ovf_sticky_b", {31'd0, overflow_b}, 32'd1);
      checkOutput("ovf_clear_a", {31'd0, overflow}, 32'd0);

      // Asynchronous reset mid-ACCUM, then a clean reduction.
      start      = 1'b1;
      cfg_len    = 8'd3;
      cfg_signed = 1'b0;
      nextCycle();
      start = 1'b0;
      checkOutput("start_clears_ovf", {31'd0, overflow_b}, 32'd0);
      feedTerm(8'd50, 0);
      feedTerm(8'd60, 0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_acc_out", {8'd0, acc_out}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_psum_ready", {31'd0, psum_ready}, 32'd0);
      checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
      nextCycle();
      rst = 1'b0;
      nextCycle();
      applyStimulus(1'b0, 8'd2, 24'd6, 1'b0, 9'd6, 1'b0);
      feedTerm(8'd1, 0);
      feedTerm(8'd2, 0);
      feedTerm(8'd3, 0);
      finishRed();

      nextCycle();
      checkOutput("scoreboard_empty_a", exp_q_a.size(), 32'd0);
      checkOutput("scoreboard_empty_b", exp_q_b.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
